// File: rtl/instruction_set_model.sv
// instruction_set_model: a small multi-cycle processor. It fetches 32-bit
// instructions from an external instruction memory, reads operands from an
// external data memory, and writes one result word back per ALU instruction.
// Bit 0 of every external word is the MSB. Internally all words are held in
// conventional [WIDTH-1:0] order, so numeric bit 0 is the LSB.
// All outputs come straight from registers. The debug input freezes every
// register; reset overrides debug and any state.
module instruction_set_model #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                debug,
    output logic [6:0]          debuger,
    output logic [ADDRSIZE-1:0] MEM_ADDR,
    input  logic [0:WIDTH-1]    MEM_IN,
    output logic [0:WIDTH-1]    MEM_OUT,
    output logic                MEM_CTRL,
    output logic [ADDRSIZE-1:0] INS_ADDR,
    input  logic [0:WIDTH-1]    INS_MEM
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_RD_SRC = 3'd2,
        S_RD_DST = 3'd3,
        S_WRITE  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_BRA = 4'd1;
    localparam logic [3:0] OP_MOV = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_MUL = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_SHF = 4'd6;
    localparam logic [3:0] OP_ROT = 4'd7;
    localparam logic [3:0] OP_HLT = 4'd15;

    // Flag vector layout: {C, Z, N, E, P}
    localparam int F_C = 4;
    localparam int F_Z = 3;
    localparam int F_N = 2;
    localparam int F_E = 1;
    localparam int F_P = 0;

    state_t              state_q, state_d;
    logic [ADDRSIZE-1:0] pc_q, pc_d;
    logic [WIDTH-1:0]    ir_q, ir_d;
    logic [WIDTH-1:0]    sv_q, sv_d;
    logic [WIDTH-1:0]    dv_q, dv_d;
    logic [4:0]          flags_q, flags_d;
    logic [ADDRSIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]    mem_out_q, mem_out_d;
    logic                mem_ctrl_q, mem_ctrl_d;

    // External words re-ordered into numeric (MSB-left) vectors.
    logic [WIDTH-1:0] ins_w;
    logic [WIDTH-1:0] mem_in_w;
    assign ins_w    = INS_MEM;
    assign mem_in_w = MEM_IN;

    // The instruction being worked on: the fetched word while in FETCH,
    // otherwise the latched IR.
    logic [WIDTH-1:0]    cur;
    logic [3:0]          cur_op;
    logic                cur_imm;
    logic [2:0]          cur_cc;
    logic [ADDRSIZE-1:0] cur_src;
    logic [ADDRSIZE-1:0] cur_dst;
    assign cur     = (state_q == S_FETCH) ? ins_w : ir_q;
    assign cur_op  = cur[WIDTH-1 -: 4];
    assign cur_imm = cur[WIDTH-5];
    assign cur_cc  = cur[WIDTH-6 -: 3];
    assign cur_src = cur[WIDTH-9 -: ADDRSIZE];
    assign cur_dst = cur[WIDTH-9-ADDRSIZE -: ADDRSIZE];

    // Source operand as it will be latched in RD_SRC.
    logic [WIDTH-1:0] src_val;
    assign src_val = cur_imm ? WIDTH'(cur_src) : mem_in_w;

    // ALU operands: in RD_DST the destination arrives from memory this cycle;
    // in RD_SRC (MOV/CMP) the source arrives this cycle.
    logic [WIDTH-1:0] alu_dv, alu_sv;
    assign alu_dv = (state_q == S_RD_DST) ? mem_in_w : dv_q;
    assign alu_sv = (state_q == S_RD_DST) ? sv_q : src_val;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   prod;
    logic [4:0]         shamt;
    logic [WIDTH-1:0]   shf;
    logic [2*WIDTH-1:0] rot_wide;
    assign sum      = {1'b0, alu_dv} + {1'b0, alu_sv};
    assign prod     = alu_dv * alu_sv;
    assign shamt    = alu_sv[4:0];
    assign shf      = alu_dv << shamt;
    assign rot_wide = {alu_dv, alu_dv} << shamt;

    logic [WIDTH-1:0] result;
    logic             carry;
    logic [4:0]       flags_new;

    // Result and carry for the current opcode.
    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (cur_op)
            OP_MOV: result = alu_sv;
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            OP_MUL: result = prod;
            OP_CMP: result = ~alu_sv;
            OP_SHF: result = shf;
            OP_ROT: result = rot_wide[2*WIDTH-1:WIDTH];
            default: result = '0;
        endcase
    end

    assign flags_new = {carry, (result == '0), result[WIDTH-1], ~result[0], ^result};

    logic bra_taken;

    // Branch condition from the current flags.
    always_comb begin
        bra_taken = 1'b0;
        case (cur_cc)
            3'd0: bra_taken = 1'b1;
            3'd1: bra_taken = flags_q[F_C];
            3'd2: bra_taken = flags_q[F_E];
            3'd3: bra_taken = flags_q[F_P];
            3'd4: bra_taken = flags_q[F_Z];
            3'd5: bra_taken = flags_q[F_N];
            default: bra_taken = 1'b0;
        endcase
    end

    // Next-state and next-output logic; debug holds every register.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        sv_d       = sv_q;
        dv_d       = dv_q;
        flags_d    = flags_q;
        mem_addr_d = mem_addr_q;
        mem_out_d  = mem_out_q;
        mem_ctrl_d = mem_ctrl_q;
        if (!debug) begin
            mem_ctrl_d = 1'b0;
            case (state_q)
                S_RESET: state_d = S_FETCH;
                S_FETCH: begin
                    ir_d = ins_w;
                    case (cur_op)
                        OP_BRA: pc_d = bra_taken ? cur_dst : pc_q + ADDRSIZE'(1);
                        OP_HLT: state_d = S_HALT;
                        OP_MOV, OP_ADD, OP_MUL, OP_CMP, OP_SHF, OP_ROT: begin
                            state_d    = S_RD_SRC;
                            mem_addr_d = cur_src;
                        end
                        default: pc_d = pc_q + ADDRSIZE'(1);
                    endcase
                end
                S_RD_SRC: begin
                    sv_d       = src_val;
                    mem_addr_d = cur_dst;
                    if (cur_op == OP_MOV || cur_op == OP_CMP) begin
                        state_d    = S_WRITE;
                        mem_out_d  = result;
                        mem_ctrl_d = 1'b1;
                        flags_d    = flags_new;
                    end else begin
                        state_d = S_RD_DST;
                    end
                end
                S_RD_DST: begin
                    dv_d       = mem_in_w;
                    state_d    = S_WRITE;
                    mem_out_d  = result;
                    mem_ctrl_d = 1'b1;
                    flags_d    = flags_new;
                end
                S_WRITE: begin
                    pc_d    = pc_q + ADDRSIZE'(1);
                    state_d = S_FETCH;
                end
                S_HALT: state_d = S_HALT;
                default: state_d = S_RESET;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RESET;
            pc_q       <= '0;
            ir_q       <= '0;
            sv_q       <= '0;
            dv_q       <= '0;
            flags_q    <= '0;
            mem_addr_q <= '0;
            mem_out_q  <= '0;
            mem_ctrl_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            sv_q       <= sv_d;
            dv_q       <= dv_d;
            flags_q    <= flags_d;
            mem_addr_q <= mem_addr_d;
            mem_out_q  <= mem_out_d;
            mem_ctrl_q <= mem_ctrl_d;
        end
    end

    assign debuger  = {4'b0000, state_q};
    assign INS_ADDR = pc_q;
    assign MEM_ADDR = mem_addr_q;
    assign MEM_OUT  = mem_out_q;
    assign MEM_CTRL = mem_ctrl_q;

endmodule

// File: tb/tb_instruction_set_model.sv
// Bench for instruction_set_model: directed programs plus random programs,
// each compared against an instruction-level reference model that yields the
// expected fetch trace (cycle, PC), write log and final data memory.
module tb_instruction_set_model;

    logic        clk;
    logic        rst;
    logic        debug;
    logic [6:0]  debuger;
    logic [11:0] MEM_ADDR;
    logic [0:31] MEM_IN;
    logic [0:31] MEM_OUT;
    logic        MEM_CTRL;
    logic [11:0] INS_ADDR;
    logic [0:31] INS_MEM;

    logic [31:0] imem   [0:4095];
    logic [31:0] dmem   [0:4095];
    logic [31:0] m_dmem [0:4095];

    logic [31:0] exp_f[$];
    logic [31:0] obs_f[$];
    logic [43:0] exp_w[$];
    logic [43:0] obs_w[$];

    int n_checks;
    int n_fail;

    instruction_set_model #(.WIDTH(32), .ADDRSIZE(12)) dut (
        .clk      (clk),
        .rst      (rst),
        .debug    (debug),
        .debuger  (debuger),
        .MEM_ADDR (MEM_ADDR),
        .MEM_IN   (MEM_IN),
        .MEM_OUT  (MEM_OUT),
        .MEM_CTRL (MEM_CTRL),
        .INS_ADDR (INS_ADDR),
        .INS_MEM  (INS_MEM)
    );

    assign MEM_IN  = dmem[MEM_ADDR];
    assign INS_MEM = imem[INS_ADDR];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int op, input int imm, input int cc,
                                        input int src, input int dst);
        return {op[3:0], imm[0], cc[2:0], src[11:0], dst[11:0]};
    endfunction

    function automatic logic [15:0] obs_pc(input int i);
        if (i < obs_f.size()) return {4'h0, obs_f[i][11:0]};
        return 16'hFFFF;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) begin
            imem[i] = enc(15, 0, 0, 0, 0);
            dmem[i] = 32'h0;
        end
    endtask

    // Reference model: executes the program instruction by instruction.
    task automatic model_run();
        logic [11:0]     pc;
        logic [31:0]     w;
        int              cyc, op, imm, cc;
        logic [11:0]     src, dst;
        longint unsigned sv, dv, r, mask;
        int              s;
        bit              fc, fz, fn, fe, fp, c, taken, halted;
        mask = 64'hFFFF_FFFF;
        pc = 0; cyc = 0; halted = 0;
        fc = 0; fz = 0; fn = 0; fe = 0; fp = 0;
        exp_f.delete();
        exp_w.delete();
        for (int i = 0; i < 4096; i++) m_dmem[i] = dmem[i];
        for (int k = 0; k < 3000 && !halted; k++) begin
            w   = imem[pc];
            exp_f.push_back({cyc[19:0], pc});
            op  = int'(w >> 28);
            imm = int'((w >> 27) & 1);
            cc  = int'((w >> 24) & 7);
            src = 12'((w >> 12) & 32'hFFF);
            dst = 12'(w & 32'hFFF);
            if (op == 15) begin
                halted = 1;
            end else if (op == 1) begin
                case (cc)
                    0: taken = 1;
                    1: taken = fc;
                    2: taken = fe;
                    3: taken = fp;
                    4: taken = fz;
                    5: taken = fn;
                    default: taken = 0;
                endcase
                pc  = taken ? dst : pc + 12'd1;
                cyc = cyc + 1;
            end else if (op == 0 || op >= 8) begin
                pc  = pc + 12'd1;
                cyc = cyc + 1;
            end else begin
                sv = (imm != 0) ? longint'(src) : longint'(m_dmem[src]);
                dv = longint'(m_dmem[dst]);
                c  = 0;
                s  = int'(sv % 32);
                case (op)
                    2: r = sv;
                    3: begin r = dv + sv; c = (r > mask); r = r & mask; end
                    4: r = (dv * sv) & mask;
                    5: r = sv ^ mask;
                    6: r = (dv << s) & mask;
                    default: r = ((dv << s) | (dv >> (32 - s))) & mask;
                endcase
                m_dmem[dst] = r[31:0];
                exp_w.push_back({dst, r[31:0]});
                fc = c;
                fz = (r == 0);
                fn = r[31];
                fe = (r[0] == 1'b0);
                fp = ^r[31:0];
                pc  = pc + 12'd1;
                cyc = cyc + ((op == 2 || op == 5) ? 3 : 4);
            end
        end
    endtask

    // Driver: hold reset three cycles and check the reset outputs.
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        debug = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_debuger", debuger, 0);
        check("rst_ins_addr", INS_ADDR, 0);
        check("rst_mem_ctrl", MEM_CTRL, 0);
        check("rst_mem_addr", MEM_ADDR, 0);
        check("rst_mem_out", MEM_OUT, 0);
        rst = 1'b0;
    endtask

    // Driver/monitor: run the loaded program until HALT, acting as data memory.
    task automatic run_prog(input bit freeze);
        int          cyc;
        bit          done, froze;
        logic [6:0]  s_dbg;
        logic [11:0] s_pc, s_ma;
        obs_f.delete();
        obs_w.delete();
        done = 0; froze = 0; cyc = 0;
        @(posedge clk);
        @(negedge clk);
        check("fetch_after_reset", debuger, 1);
        for (int k = 0; k < 3000 && !done; k++) begin
            if (debuger == 7'd1) obs_f.push_back({cyc[19:0], INS_ADDR});
            if (MEM_CTRL === 1'b1) begin
                obs_w.push_back({MEM_ADDR, 32'(MEM_OUT)});
                dmem[MEM_ADDR] = MEM_OUT;
            end
            if (debuger == 7'd5) begin
                done = 1;
            end else begin
                if (freeze && !froze && debuger == 7'd3) begin
                    froze = 1;
                    s_dbg = debuger;
                    s_pc  = INS_ADDR;
                    s_ma  = MEM_ADDR;
                    debug = 1'b1;
                    for (int j = 0; j < 3; j++) begin
                        @(posedge clk);
                        @(negedge clk);
                        check("frz_debuger", debuger, s_dbg);
                        check("frz_ins_addr", INS_ADDR, s_pc);
                        check("frz_mem_addr", MEM_ADDR, s_ma);
                        check("frz_mem_ctrl", MEM_CTRL, 0);
                    end
                    debug = 1'b0;
                end
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
        end
        check("halt_reached", done, 1);
        if (freeze) check("freeze_applied", froze, 1);
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            @(negedge clk);
            check("halt_hold", debuger, 5);
            check("halt_no_write", MEM_CTRL, 0);
        end
    endtask

    // Scoreboard: compare fetch trace, write log and data memory with the model.
    task automatic compare_all(input string tag);
        int n;
        check({tag, "_nfetch"}, obs_f.size(), exp_f.size());
        n = (obs_f.size() < exp_f.size()) ? obs_f.size() : exp_f.size();
        for (int i = 0; i < n; i++) check({tag, "_fetch"}, obs_f[i], exp_f[i]);
        check({tag, "_nwrite"}, obs_w.size(), exp_w.size());
        n = (obs_w.size() < exp_w.size()) ? obs_w.size() : exp_w.size();
        for (int i = 0; i < n; i++) check({tag, "_write"}, obs_w[i], exp_w[i]);
        for (int a = 0; a < 32; a++) check({tag, "_dmem"}, dmem[a], m_dmem[a]);
    endtask

    task automatic exec(input string tag, input bit freeze);
        model_run();
        apply_reset();
        run_prog(freeze);
        compare_all(tag);
    endtask

    task automatic load_add_prog();
        clear_mem();
        dmem[0] = 32'd5;
        dmem[1] = 32'd10;
        dmem[2] = 32'hFFFF_FFFF;
        imem[0]  = enc(3, 0, 0, 0, 1);
        imem[1]  = enc(1, 0, 4, 0, 20);
        imem[2]  = enc(3, 1, 0, 1, 2);
        imem[3]  = enc(1, 0, 4, 0, 9);
        imem[9]  = enc(3, 1, 0, 0, 0);
        imem[10] = enc(1, 0, 1, 0, 30);
    endtask

    initial begin
        int len, op, cc, imm, src, dst;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        debug    = 1'b0;

        // MOV #7 -> 3, then HLT
        clear_mem();
        imem[0] = enc(2, 1, 0, 7, 3);
        exec("mov", 0);
        check("mov_mem3", dmem[3], 7);
        check("mov_one_pulse", obs_w.size(), 1);

        // ADD with and without carry, conditional branches on Z and C
        load_add_prog();
        exec("add", 0);
        check("add_mem1", dmem[1], 15);
        check("add_mem2", dmem[2], 0);
        check("bra_z_not_taken", obs_pc(2), 2);
        check("bra_z_taken", obs_pc(4), 9);
        check("bra_c_not_taken", obs_pc(6), 11);

        // Same program frozen for three cycles inside RD_DST
        load_add_prog();
        exec("freeze", 1);
        check("freeze_mem1", dmem[1], 15);

        // ROT, SHF, MUL, CMP, branch on N
        clear_mem();
        dmem[4] = 32'h8000_0001;
        dmem[5] = 32'd3;
        imem[0] = enc(7, 1, 0, 1, 4);
        imem[1] = enc(6, 1, 0, 1, 4);
        imem[2] = enc(4, 1, 0, 4, 5);
        imem[3] = enc(5, 1, 0, 0, 6);
        imem[4] = enc(1, 0, 5, 0, 20);
        imem[5] = enc(2, 1, 0, 1, 7);
        exec("alu", 0);
        check("rot_result", obs_w.size() > 0 ? obs_w[0] : 44'h0, {12'd4, 32'h0000_0003});
        check("shf_mem4", dmem[4], 32'h0000_0006);
        check("mul_mem5", dmem[5], 12);
        check("cmp_mem6", dmem[6], 32'hFFFF_FFFF);
        check("bra_n_taken", obs_pc(5), 20);
        check("skipped_mem7", dmem[7], 0);

        // PC wrap 4095 -> 0
        clear_mem();
        dmem[2] = 32'hFFFF_FFFF;
        imem[0]    = enc(1, 0, 1, 0, 6);
        imem[1]    = enc(1, 0, 0, 0, 4094);
        imem[4094] = enc(3, 1, 0, 1, 2);
        imem[4095] = enc(0, 0, 0, 0, 0);
        exec("wrap", 0);
        check("wrap_pc", obs_pc(4), 0);
        check("wrap_then_bra_c", obs_pc(5), 6);

        // Reset (with debug high) during WRITE
        clear_mem();
        imem[0] = enc(2, 1, 0, 7, 3);
        apply_reset();
        for (int k = 0; k < 20 && debuger != 7'd4; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("reached_write", debuger, 4);
        rst = 1'b1;
        debug = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_in_write_debuger", debuger, 0);
        check("rst_in_write_ctrl", MEM_CTRL, 0);
        check("rst_in_write_pc", INS_ADDR, 0);
        rst = 1'b0;
        debug = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("resume_fetch", debuger, 1);

        // Random forward-branching programs
        for (int t = 0; t < 8; t++) begin
            clear_mem();
            for (int a = 0; a < 16; a++)
                dmem[a] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            len = $urandom_range(10, 24);
            for (int p = 0; p < len; p++) begin
                op  = $urandom_range(0, 14);
                cc  = $urandom_range(0, 7);
                imm = $urandom_range(0, 1);
                src = imm ? $urandom_range(0, 4095) : $urandom_range(0, 15);
                dst = (op == 1) ? p + 1 + $urandom_range(0, 3) : $urandom_range(0, 15);
                imem[p] = enc(op, imm, cc, src, dst);
            end
            exec("rand", 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_set_model.md
INSTRUCTION_SET_MODEL -- requirements
Module: instruction_set_model

Interface
REQ-001 Parameter: WIDTH, 32, data/instruction word width.
REQ-002 Parameter: ADDRSIZE, 12, data and instruction address width.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 debug  in  1  1 = freeze: no state, PC, register or output change.
REQ-006 debuger  out  7  current FSM state code (REQ-012).
REQ-007 MEM_ADDR  out  ADDRSIZE  data memory address; memory returns MEM_IN combinationally.
REQ-008 MEM_IN  in  [0:WIDTH-1]  data read word.
REQ-009 MEM_OUT  out  [0:WIDTH-1]  data write word.
REQ-010 MEM_CTRL  out  1  write strobe; memory writes MEM[MEM_ADDR]=MEM_OUT while 1.
REQ-011 INS_ADDR  out  ADDRSIZE  program counter; INS_MEM [0:WIDTH-1] in returns instruction combinationally.

Function
REQ-012 States/debuger codes: RESET=0, FETCH=1, RD_SRC=2, RD_DST=3, WRITE=4, HALT=5; all outputs registered.
REQ-013 Word bit 0 is MSB. Instruction: [0:3] opcode, [4] src_type (1=immediate), [5:7] cc, [8:19] src, [20:31] dst.
REQ-014 Opcodes: 0 NOP, 1 BRA, 2 MOV, 3 ADD, 4 MUL, 5 CMP, 6 SHF, 7 ROT, 15 HLT; 8-14 execute as NOP.
REQ-015 RESET -> FETCH unconditionally next cycle.
REQ-016 FETCH: IR <= INS_MEM (at INS_ADDR=PC); next: NOP -> PC+1, FETCH; BRA -> PC <= cond ? dst : PC+1, FETCH; HLT -> HALT; others -> RD_SRC.
REQ-017 RD_SRC: MEM_ADDR=src; SV <= src_type ? zero-extended 12-bit src : MEM_IN; MOV/CMP -> WRITE, else -> RD_DST.
REQ-018 RD_DST: MEM_ADDR=dst; DV <= MEM_IN; -> WRITE.
REQ-019 WRITE: MEM_ADDR=dst, MEM_OUT=result, MEM_CTRL=1 for exactly this one cycle, all stable whole cycle; flags update; PC+1; -> FETCH.
REQ-020 MEM_CTRL SHALL be 0 in every state except WRITE.
REQ-021 Results: MOV=SV; ADD=(DV+SV) mod 2^32; MUL=low 32 bits of DV*SV; CMP=~SV; SHF=DV logical left shift by SV[4:0] (numeric LSBs); ROT=DV rotate left by SV[4:0].
REQ-022 Flags on WRITE: C=carry-out of ADD (0 for other ops); Z=result==0; N=result MSB; E=result LSB==0; P=XOR of all result bits.
REQ-023 BRA cc: 0 always, 1 C, 2 E, 3 P, 4 Z, 5 N, 6-7 never; BRA leaves flags unchanged.
REQ-024 PC increment wraps 4095 -> 0.
REQ-025 HALT: held until reset; debuger=5, MEM_CTRL=0.
REQ-026 debug=1 at a clock edge: entire design holds; resumes exactly where frozen when debug=0.
REQ-027 Latency: NOP/BRA 1 cycle, MOV/CMP 3 cycles, ADD/MUL/SHF/ROT 4 cycles, fetch to next FETCH.

Reset
REQ-028 rst=1 at rising edge: state RESET (debuger=0), PC/INS_ADDR=0, MEM_ADDR=0, MEM_OUT=0, MEM_CTRL=0, IR=0, SV=DV=0, flags=0.
REQ-029 Reset SHALL override debug, HALT and any mid-instruction state, including WRITE (no further write).
REQ-030 Before the first reset, outputs are undefined; nothing is required of them.

Verification
REQ-031 rst=1 three cycles -> debuger=0, INS_ADDR=0, MEM_CTRL=0; one cycle after release debuger=1.
REQ-032 I_MEM[0]=MOV #7->3, I_MEM[1]=HLT -> MEM[3]=7, single MEM_CTRL pulse, then debuger=5 and stays 5.
REQ-033 MEM[0]=5, MEM[1]=10, ADD MEM[0]->1 -> MEM[1]=15, Z=0, C=0; MEM[2]=0xFFFFFFFF, ADD #1->2 -> MEM[2]=0, C=1, Z=1.
REQ-034 After that ADD, BRA cc=4 dst=9 -> INS_ADDR=9; BRA cc=1 after ADD with C=0 -> INS_ADDR=PC+1.
REQ-035 MEM[4]=0x80000001, ROT #1->4 -> 0x00000003; SHF #1->4 -> 0x00000006; MUL MEM[5]=3 by #4 -> 12; CMP #0->6 -> 0xFFFFFFFF, N=1.
REQ-036 debug=1 for 3 cycles during RD_DST -> debuger, INS_ADDR, MEM_ADDR unchanged, no write; after release instruction completes with correct result.
